// File: rtl/csr_bus_pkg.sv
// Shared encodings for the CSR bus arbiter: access ops, FSM states and the
// read-only address prefix.
package csr_bus_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10
  } arb_state_e;

  localparam logic [1:0] RO_PREFIX = 2'b11;

endpackage

// File: rtl/csr_rmw_unit.sv
// Combinational read-modify-write helper: write value, whether a write is
// needed at all, and whether that write targets a read-only address.
module csr_rmw_unit
  import csr_bus_pkg::*;
(
  input  csr_op_e             i_op,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W-1:0]   i_old,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   o_wval,
  output logic                o_write_needed,
  output logic                o_ro_violation
);

  logic w_mask_nonzero;

  assign w_mask_nonzero = |i_wdata;

  always_comb begin
    o_wval         = i_wdata;
    o_write_needed = 1'b0;
    case (i_op)
      OP_RW: begin
        o_wval         = i_wdata;
        o_write_needed = 1'b1;
      end
      OP_RS: begin
        o_wval         = i_old | i_wdata;
        o_write_needed = w_mask_nonzero;
      end
      OP_RC: begin
        o_wval         = i_old & ~i_wdata;
        o_write_needed = w_mask_nonzero;
      end
      default: begin
        o_wval         = i_wdata;
        o_write_needed = 1'b0;
      end
    endcase
  end

  assign o_ro_violation = o_write_needed && (i_addr[ADDR_W-1:ADDR_W-2] == RO_PREFIX);

endmodule

// File: rtl/csr_bus_arbiter.sv
// Two-port (core / mgmt) CSR access arbiter with a 3-cycle IDLE/READ/WRITE
// sequence. Define CSR_ARBITER_ROUND_ROBIN_EN for round-robin on collisions.
module csr_bus_arbiter
  import csr_bus_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                coreRequest,
  input  logic [ADDR_W-1:0]   coreAddress,
  input  logic [1:0]          coreOp,
  input  logic [DATA_W-1:0]   coreWriteData,
  output logic [DATA_W-1:0]   coreReadData,
  output logic                coreDone,
  output logic                coreError,
  input  logic                mgmtRequest,
  input  logic [ADDR_W-1:0]   mgmtAddress,
  input  logic [1:0]          mgmtOp,
  input  logic [DATA_W-1:0]   mgmtWriteData,
  output logic [DATA_W-1:0]   mgmtReadData,
  output logic                mgmtDone,
  output logic                mgmtError,
  output logic                csrReadEnable,
  output logic                csrWriteEnable,
  output logic [ADDR_W-1:0]   csrReadAddress,
  output logic [ADDR_W-1:0]   csrWriteAddress,
  output logic [DATA_W-1:0]   csrWriteData,
  input  logic [DATA_W-1:0]   csrReadData,
  input  logic                csrRequestOutput
);

  arb_state_e          r_state;
  logic                r_sel_mgmt;
  logic [ADDR_W-1:0]   r_addr;
  csr_op_e             r_op;
  logic [DATA_W-1:0]   r_wdata;

  logic                r_csr_re;
  logic                r_csr_we;
  logic [ADDR_W-1:0]   r_csr_raddr;
  logic [ADDR_W-1:0]   r_csr_waddr;
  logic [DATA_W-1:0]   r_csr_wdata;

  logic [DATA_W-1:0]   r_core_rdata;
  logic                r_core_done;
  logic                r_core_err;
  logic [DATA_W-1:0]   r_mgmt_rdata;
  logic                r_mgmt_done;
  logic                r_mgmt_err;

  logic                w_grant;
  logic                w_pick_mgmt;
  logic [DATA_W-1:0]   w_wval;
  logic                w_write_needed;
  logic                w_ro_violation;
  logic                w_err;
  logic                w_we;
  logic [DATA_W-1:0]   w_rdata;

  assign w_grant = coreRequest | mgmtRequest;

`ifdef CSR_ARBITER_ROUND_ROBIN_EN
  // r_core_last = 0 means mgmt was granted last, so core wins first after reset
  logic r_core_last;

  assign w_pick_mgmt = mgmtRequest && (!coreRequest || r_core_last);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_core_last <= 1'b0;
    end else if (r_state == ST_IDLE && w_grant) begin
      r_core_last <= !w_pick_mgmt;
    end
  end
`else
  assign w_pick_mgmt = mgmtRequest && !coreRequest;
`endif

  csr_rmw_unit u_rmw (
    .i_op           (r_op),
    .i_wdata        (r_wdata),
    .i_old          (csrReadData),
    .i_addr         (r_addr),
    .o_wval         (w_wval),
    .o_write_needed (w_write_needed),
    .o_ro_violation (w_ro_violation)
  );

  assign w_err   = !csrRequestOutput || w_ro_violation;
  assign w_we    = w_write_needed && !w_err;
  assign w_rdata = csrRequestOutput ? csrReadData : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_sel_mgmt   <= 1'b0;
      r_addr       <= '0;
      r_op         <= OP_READ;
      r_wdata      <= '0;
      r_csr_re     <= 1'b0;
      r_csr_we     <= 1'b0;
      r_csr_raddr  <= '0;
      r_csr_waddr  <= '0;
      r_csr_wdata  <= '0;
      r_core_rdata <= '0;
      r_core_done  <= 1'b0;
      r_core_err   <= 1'b0;
      r_mgmt_rdata <= '0;
      r_mgmt_done  <= 1'b0;
      r_mgmt_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state     <= ST_READ;
            r_sel_mgmt  <= w_pick_mgmt;
            r_addr      <= w_pick_mgmt ? mgmtAddress : coreAddress;
            r_op        <= csr_op_e'(w_pick_mgmt ? mgmtOp : coreOp);
            r_wdata     <= w_pick_mgmt ? mgmtWriteData : coreWriteData;
            r_csr_re    <= 1'b1;
            r_csr_raddr <= w_pick_mgmt ? mgmtAddress : coreAddress;
          end
        end
        ST_READ: begin
          // Read data is captured here; the WRITE cycle only replays registers.
          r_state     <= ST_WRITE;
          r_csr_re    <= 1'b0;
          r_csr_we    <= w_we;
          r_csr_waddr <= r_addr;
          r_csr_wdata <= w_wval;
          if (r_sel_mgmt) begin
            r_mgmt_done  <= 1'b1;
            r_mgmt_rdata <= w_rdata;
            r_mgmt_err   <= w_err;
          end else begin
            r_core_done  <= 1'b1;
            r_core_rdata <= w_rdata;
            r_core_err   <= w_err;
          end
        end
        ST_WRITE: begin
          r_state     <= ST_IDLE;
          r_csr_we    <= 1'b0;
          r_csr_raddr <= '0;
          r_csr_waddr <= '0;
          r_csr_wdata <= '0;
          r_core_done <= 1'b0;
          r_mgmt_done <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign csrReadEnable   = r_csr_re;
  assign csrWriteEnable  = r_csr_we;
  assign csrReadAddress  = r_csr_raddr;
  assign csrWriteAddress = r_csr_waddr;
  assign csrWriteData    = r_csr_wdata;
  assign coreReadData    = r_core_rdata;
  assign coreDone        = r_core_done;
  assign coreError       = r_core_err;
  assign mgmtReadData    = r_mgmt_rdata;
  assign mgmtDone        = r_mgmt_done;
  assign mgmtError       = r_mgmt_err;

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// Directed self-checking bench for csr_bus_arbiter; expectations follow the
// CSR_ARBITER_ROUND_ROBIN_EN setting of the build.
module tb_csr_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        coreRequest = 1'b0;
  logic [11:0] coreAddress = '0;
  logic [1:0]  coreOp = '0;
  logic [31:0] coreWriteData = '0;
  logic [31:0] coreReadData;
  logic        coreDone;
  logic        coreError;
  logic        mgmtRequest = 1'b0;
  logic [11:0] mgmtAddress = '0;
  logic [1:0]  mgmtOp = '0;
  logic [31:0] mgmtWriteData = '0;
  logic [31:0] mgmtReadData;
  logic        mgmtDone;
  logic        mgmtError;
  logic        csrReadEnable;
  logic        csrWriteEnable;
  logic [11:0] csrReadAddress;
  logic [11:0] csrWriteAddress;
  logic [31:0] csrWriteData;
  logic [31:0] csrReadData;
  logic        csrRequestOutput;

  logic [31:0] tb_old = '0;
  logic        tb_hit = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // Simple CSR register model: only answers while the arbiter reads.
  assign csrReadData      = csrReadEnable ? tb_old : 32'h0;
  assign csrRequestOutput = csrReadEnable & tb_hit;

  always #5 clk = ~clk;

  csr_bus_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .coreRequest      (coreRequest),
    .coreAddress      (coreAddress),
    .coreOp           (coreOp),
    .coreWriteData    (coreWriteData),
    .coreReadData     (coreReadData),
    .coreDone         (coreDone),
    .coreError        (coreError),
    .mgmtRequest      (mgmtRequest),
    .mgmtAddress      (mgmtAddress),
    .mgmtOp           (mgmtOp),
    .mgmtWriteData    (mgmtWriteData),
    .mgmtReadData     (mgmtReadData),
    .mgmtDone         (mgmtDone),
    .mgmtError        (mgmtError),
    .csrReadEnable    (csrReadEnable),
    .csrWriteEnable   (csrWriteEnable),
    .csrReadAddress   (csrReadAddress),
    .csrWriteAddress  (csrWriteAddress),
    .csrWriteData     (csrWriteData),
    .csrReadData      (csrReadData),
    .csrRequestOutput (csrRequestOutput)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus_idle(input string tag);
    check_eq({tag, " re"}, {31'h0, csrReadEnable}, 32'h0);
    check_eq({tag, " we"}, {31'h0, csrWriteEnable}, 32'h0);
    check_eq({tag, " raddr"}, {20'h0, csrReadAddress}, 32'h0);
    check_eq({tag, " waddr"}, {20'h0, csrWriteAddress}, 32'h0);
    check_eq({tag, " wdata"}, csrWriteData, 32'h0);
  endtask

  task automatic run_access(input string tag, input bit is_mgmt, input logic [11:0] addr,
                            input logic [1:0] op, input logic [31:0] wd,
                            input logic [31:0] old, input bit hit,
                            input bit exp_we, input logic [31:0] exp_wd,
                            input logic [31:0] exp_rd, input bit exp_err);
    tb_old = old;
    tb_hit = hit;
    if (is_mgmt) begin
      mgmtRequest = 1'b1; mgmtAddress = addr; mgmtOp = op; mgmtWriteData = wd;
    end else begin
      coreRequest = 1'b1; coreAddress = addr; coreOp = op; coreWriteData = wd;
    end
    tick();
    check_eq({tag, " read re"}, {31'h0, csrReadEnable}, 32'h1);
    check_eq({tag, " read raddr"}, {20'h0, csrReadAddress}, {20'h0, addr});
    check_eq({tag, " read done"}, {30'h0, coreDone, mgmtDone}, 32'h0);
    tick();
    check_eq({tag, " done"}, {30'h0, coreDone, mgmtDone}, is_mgmt ? 32'h1 : 32'h2);
    check_eq({tag, " we"}, {31'h0, csrWriteEnable}, {31'h0, exp_we});
    check_eq({tag, " waddr"}, {20'h0, csrWriteAddress}, {20'h0, addr});
    if (exp_we) check_eq({tag, " wdata"}, csrWriteData, exp_wd);
    check_eq({tag, " rdata"}, is_mgmt ? mgmtReadData : coreReadData, exp_rd);
    check_eq({tag, " err"}, {31'h0, is_mgmt ? mgmtError : coreError}, {31'h0, exp_err});
    coreRequest = 1'b0;
    mgmtRequest = 1'b0;
    tick();
    check_eq({tag, " after done"}, {30'h0, coreDone, mgmtDone}, 32'h0);
    check_bus_idle({tag, " after"});
  endtask

  initial begin
    bit exp_core [3];
`ifdef CSR_ARBITER_ROUND_ROBIN_EN
    exp_core = '{1'b1, 1'b0, 1'b1};
`else
    exp_core = '{1'b1, 1'b1, 1'b1};
`endif

    // Reset state
    #1;
    tick(); tick();
    check_bus_idle("reset");
    check_eq("reset core", {coreReadData[30:0] | 31'h0, coreDone} | {31'h0, coreError}, 32'h0);
    check_eq("reset mgmt", {mgmtReadData[30:0] | 31'h0, mgmtDone} | {31'h0, mgmtError}, 32'h0);
    rst = 1'b1;
    tick();

    // Core accesses
    run_access("core rw",  1'b0, 12'h300, 2'b01, 32'h0000_1888, 32'h8, 1'b1, 1'b1, 32'h0000_1888, 32'h8, 1'b0);
    run_access("core rs0", 1'b0, 12'h304, 2'b10, 32'h0, 32'hA, 1'b1, 1'b0, 32'h0, 32'hA, 1'b0);
    run_access("core rc",  1'b0, 12'h304, 2'b11, 32'h2, 32'hA, 1'b1, 1'b1, 32'h8, 32'hA, 1'b0);
    run_access("core rd",  1'b0, 12'h3FC, 2'b00, 32'h1234, 32'hDEAD, 1'b1, 1'b0, 32'h0, 32'hDEAD, 1'b0);

    // Management accesses: read-only violation, miss, set
    run_access("mgmt ro",   1'b1, 12'hC00, 2'b01, 32'h77, 32'h55, 1'b1, 1'b0, 32'h0, 32'h55, 1'b1);
    run_access("mgmt miss", 1'b1, 12'h7FF, 2'b00, 32'h0, 32'h99, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    run_access("mgmt rs",   1'b1, 12'h010, 2'b10, 32'h10, 32'h1, 1'b1, 1'b1, 32'h11, 32'h1, 1'b0);
    run_access("mgmt rs ro0", 1'b1, 12'hC04, 2'b10, 32'h0, 32'h3, 1'b1, 1'b0, 32'h0, 32'h3, 1'b0);

    check_eq("core rdata hold", coreReadData, 32'hDEAD);
    check_eq("core err hold", {31'h0, coreError}, 32'h0);

    // Simultaneous requests from a fresh pointer
    rst = 1'b0; tick(); rst = 1'b1;
    tb_old = 32'h1; tb_hit = 1'b1;
    coreAddress = 12'h100; coreOp = 2'b00; coreWriteData = '0;
    mgmtAddress = 12'h200; mgmtOp = 2'b00; mgmtWriteData = '0;
    coreRequest = 1'b1; mgmtRequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("both raddr %0d", i), {20'h0, csrReadAddress},
               exp_core[i] ? 32'h100 : 32'h200);
      tick();
      check_eq($sformatf("both done %0d", i), {30'h0, coreDone, mgmtDone},
               exp_core[i] ? 32'h2 : 32'h1);
      tick();
    end
    coreRequest = 1'b0; mgmtRequest = 1'b0;
    tick();

    // Reset during READ of an RW access
    tb_old = 32'h1; tb_hit = 1'b1;
    coreRequest = 1'b1; coreAddress = 12'h308; coreOp = 2'b01; coreWriteData = 32'h5;
    tick();
    check_eq("abort read re", {31'h0, csrReadEnable}, 32'h1);
    rst = 1'b0;
    tick();
    check_bus_idle("abort");
    check_eq("abort done", {30'h0, coreDone, mgmtDone}, 32'h0);
    check_eq("abort rdata", coreReadData, 32'h0);
    coreRequest = 1'b0;
    rst = 1'b1;
    tick();
    check_bus_idle("abort idle");
    run_access("reissue", 1'b0, 12'h308, 2'b01, 32'h5, 32'h1, 1'b1, 1'b1, 32'h5, 32'h1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csr_bus_arbiter.md
CSR_BUS_ARBITER -- requirements
Module: csr_bus_arbiter

Interface
REQ-001 The block SHALL have no parameters; all encodings come from the shared package.
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 coreRequest  input  1  core pipeline access request, held until coreDone.
REQ-005 coreAddress  input  12  core CSR address.
REQ-006 coreOp  input  2  access op: 00 READ, 01 RW, 10 RS (set), 11 RC (clear).
REQ-007 coreWriteData  input  32  write value or set/clear mask.
REQ-008 coreReadData  output  32  old CSR value, valid with coreDone.
REQ-009 coreDone  output  1  one-cycle completion pulse.
REQ-010 coreError  output  1  error flag, valid with coreDone.
REQ-011 mgmtRequest, mgmtAddress, mgmtOp, mgmtWriteData, mgmtReadData, mgmtDone, mgmtError  SHALL have the same directions, widths and meanings as the core port, for the management/debug requester.
REQ-012 csrReadEnable, csrWriteEnable  output  1  CSR bus strobes.
REQ-013 csrReadAddress, csrWriteAddress  output  12  CSR bus addresses.
REQ-014 csrWriteData  output  32  CSR bus write value.
REQ-015 csrReadData  input  32  OR-combined read data from all CSR registers.
REQ-016 csrRequestOutput  input  1  OR-combined hit from all CSR registers.

Function
REQ-017 FSM states SHALL be IDLE, READ and WRITE; IDLE->READ on grant, READ->WRITE always, WRITE->IDLE always.
REQ-018 In IDLE, a grant SHALL latch the winning port's address, op and data into internal registers.
REQ-019 In READ, the block SHALL drive csrReadEnable=1 and csrReadAddress=latched address, and SHALL register csrReadData and csrRequestOutput at the end of the cycle.
REQ-020 In WRITE, the block SHALL assert the granted port's Done for exactly one cycle, with ReadData=captured value.
REQ-021 Latency: request first seen high in cycle N -> Done in cycle N+2; one access per 3 cycles maximum.
REQ-022 Write value: RW=wdata; RS=old|wdata; RC=old&~wdata.
REQ-023 In WRITE, csrWriteEnable SHALL be 1 only when all of the following hold: op != READ; not (RS/RC with wdata==0); no error. csrWriteAddress SHALL equal csrReadAddress.
REQ-024 Error SHALL be raised on a miss (captured csrRequestOutput==0); ReadData SHALL then be 0.
REQ-025 Error SHALL be raised when op is RW, or RS/RC with nonzero mask, to a read-only address (address[11:10]==2'b11); no write SHALL occur and ReadData SHALL still return the old value.
REQ-026 Requesters SHALL deassert Request in the cycle after Done; a Request high in IDLE is always a new access.
REQ-027 Requests arriving while not in IDLE SHALL wait; no request SHALL be dropped.
REQ-028 ReadData and Error SHALL hold their last value until that port's next Done.
REQ-029 Outside READ and WRITE, every CSR bus output SHALL be 0.

Reset
REQ-030 While rst=0, the FSM SHALL go to IDLE and all outputs, captured data and the round-robin pointer SHALL go to 0.
REQ-031 Reset mid-access SHALL abort it with no write and no Done; the requester re-issues the access.

Configuration
REQ-032 With CSR_ARBITER_ROUND_ROBIN_EN defined, on simultaneous requests the port not granted last SHALL win; the pointer updates on each grant and resets to "mgmt last", so core wins first.
REQ-033 Without CSR_ARBITER_ROUND_ROBIN_EN, core SHALL always win simultaneous requests and no pointer register SHALL exist.

Structure
REQ-034 Package csr_bus_pkg SHALL hold the op encodings, FSM state encoding and the read-only prefix constant 2'b11.
REQ-035 Sub-module csr_rmw_unit (combinational) SHALL compute the write value, write-needed and read-only-violation from op, wdata, old value and address.

Verification
REQ-036 Core RW 0x300 wdata=0x0000_1888, old=0x0000_0008, hit -> read in N+1; write 0x1888 and coreDone in N+2; coreReadData=0x8, coreError=0.
REQ-037 Core RS 0x304 mask=0, old=0xA -> csrWriteEnable stays 0; coreReadData=0xA. Then RC mask=0x2 -> write value 0x8.
REQ-038 mgmt RW 0xC00 (read-only), hit, old=0x55 -> no write; mgmtError=1; mgmtReadData=0x55. Then READ 0x7FF with no hit -> mgmtError=1, mgmtReadData=0.
REQ-039 Core and mgmt both request every cycle -> with _EN: grants alternate core, mgmt, core; without it: core always wins and mgmt never completes while core keeps requesting.
REQ-040 rst=0 asserted during READ of an RW access -> no csrWriteEnable and no Done; next cycle in IDLE with all outputs 0; re-issued request completes normally.
